// File: rtl/mem_req_router.sv
// Routes one CPU request at a time to either the cache port or a Wishbone classic master.
// Define MEM_REQ_ROUTER_TIMEOUT_EN to add the uncached watchdog (limit TIMEOUT_CYCLES).
module mem_req_router #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SW            = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic          i_req_we,
  input  logic [DW-1:0] i_req_wdata,
  input  logic [SW-1:0] i_req_sel,
  input  logic          i_cachable,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_c_valid,
  input  logic          i_c_ready,
  output logic [AW-1:0] o_c_addr,
  output logic          o_c_we,
  output logic [DW-1:0] o_c_wdata,
  output logic [SW-1:0] o_c_sel,
  input  logic          i_c_rsp_valid,
  input  logic [DW-1:0] i_c_rdata,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [SW-1:0] o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data
);

  typedef enum logic [2:0] {
    IDLE,
    CACHE_REQ,
    CACHE_WAIT,
    WB,
    RESP
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] sel_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic accept;
  logic c_done;
  logic wb_done;
  logic timeout_hit;

  assign accept  = (state == IDLE) && i_req_valid;
  assign c_done  = (state == CACHE_WAIT) && i_c_rsp_valid;
  assign wb_done = (state == WB) && (i_wb_ack || i_wb_err);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef MEM_REQ_ROUTER_TIMEOUT_EN
  // Counts WB cycles without ack/err; held at zero outside WB so every entry starts fresh.
  logic [15:0] wd_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wd_cnt <= '0;
    end else if (state != WB || wb_done) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state == WB) && !wb_done &&
                       (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept) state_next = i_cachable ? CACHE_REQ : WB;
      CACHE_REQ:  if (i_c_ready) state_next = CACHE_WAIT;
      CACHE_WAIT: if (i_c_rsp_valid) state_next = RESP;
      WB:         if (wb_done || timeout_hit) state_next = RESP;
      RESP:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; response data is zeroed for writes and timeouts.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= i_req_addr;
        we_q    <= i_req_we;
        wdata_q <= i_req_wdata;
        sel_q   <= i_req_sel;
      end
      if (c_done) begin
        rdata_q <= we_q ? '0 : i_c_rdata;
        err_q   <= 1'b0;
      end else if (wb_done) begin
        rdata_q <= we_q ? '0 : i_wb_data;
        err_q   <= i_wb_err;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign o_req_ready = (state == IDLE);

  assign o_c_valid = (state == CACHE_REQ);
  assign o_c_addr  = addr_q;
  assign o_c_we    = we_q;
  assign o_c_wdata = wdata_q;
  assign o_c_sel   = sel_q;

  assign o_wb_cyc  = (state == WB);
  assign o_wb_stb  = (state == WB);
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;
  assign o_wb_sel  = sel_q;

  assign o_rsp_valid = (state == RESP);
  assign o_rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign o_rsp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_mem_req_router.sv
// Self-checking bench for mem_req_router: vector table plus response scoreboard.
// Covers the watchdog when MEM_REQ_ROUTER_TIMEOUT_EN is defined, else the unbounded wait.
module tb_mem_req_router;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_req_we = 1'b0;
  logic [DW-1:0] i_req_wdata = '0;
  logic [SW-1:0] i_req_sel = '0;
  logic          i_cachable = 1'b0;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_c_valid;
  logic          i_c_ready = 1'b0;
  logic [AW-1:0] o_c_addr;
  logic          o_c_we;
  logic [DW-1:0] o_c_wdata;
  logic [SW-1:0] o_c_sel;
  logic          i_c_rsp_valid = 1'b0;
  logic [DW-1:0] i_c_rdata = '0;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [SW-1:0] o_wb_sel;
  logic          i_wb_ack = 1'b0;
  logic          i_wb_err = 1'b0;
  logic [DW-1:0] i_wb_data = '0;

  mem_req_router #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_we(i_req_we), .i_req_wdata(i_req_wdata), .i_req_sel(i_req_sel),
    .i_cachable(i_cachable),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_c_valid(o_c_valid), .i_c_ready(i_c_ready), .o_c_addr(o_c_addr), .o_c_we(o_c_we),
    .o_c_wdata(o_c_wdata), .o_c_sel(o_c_sel), .i_c_rsp_valid(i_c_rsp_valid),
    .i_c_rdata(i_c_rdata),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  typedef struct {
    logic          cach;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    int            d1;
    int            d2;
    logic [DW-1:0] sdata;
    logic          serr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;
  int   rsp_seen = 0;
  logic wb_seen = 1'b0;
  logic cache_seen = 1'b0;
  time  t_acc = 0;
  time  t_rsp = 0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Passive monitor: scoreboard pops on every response, exclusivity checked when either side is busy.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_wb_cyc === 1'b1) wb_seen = 1'b1;
    if (o_c_valid === 1'b1) cache_seen = 1'b1;
    if (o_c_valid === 1'b1 || o_wb_cyc === 1'b1)
      check_output("c_wb_exclusive", {o_c_valid, o_wb_cyc} == 2'b11, 0);
    if (o_rsp_valid === 1'b1) begin
      rsp_seen++;
      t_rsp = $time;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got rdata 0x%0h err %0b, expected no response",
                 o_rsp_rdata, o_rsp_err);
      end else begin
        e = sb_q.pop_front();
        check_output("rsp_rdata", o_rsp_rdata, e.rdata);
        check_output("rsp_err", o_rsp_err, e.err);
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_req_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    check_output(name, ok, 1);
    @(posedge i_clk);
    #1;
  endtask

  // Caller is at posedge+1 with the DUT in IDLE.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    int   rsp_before = rsp_seen;
    wb_seen = 1'b0;
    cache_seen = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = v.addr;
    i_req_we    = v.we;
    i_req_wdata = v.wdata;
    i_req_sel   = v.sel;
    i_cachable  = v.cach;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb_q.push_back(e);
    @(negedge i_clk);
    t_acc = $time;
    check_output("req_ready", o_req_ready, 1);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_addr  = ~v.addr;
    i_req_we    = ~v.we;
    i_req_wdata = ~v.wdata;
    i_req_sel   = ~v.sel;
    i_cachable  = ~v.cach;
    if (v.cach) begin
      for (int k = 0; k <= v.d1; k++) begin
        i_c_ready = (k == v.d1);
        i_wb_ack  = 1'b1;
        @(negedge i_clk);
        check_output("c_req_hold", {o_c_valid, o_c_we, o_c_addr, o_c_wdata, o_c_sel},
                     {1'b1, v.we, v.addr, v.wdata, v.sel});
        @(posedge i_clk);
        #1;
      end
      i_c_ready = 1'b0;
      i_wb_ack  = 1'b0;
      for (int k = 0; k <= v.d2; k++) begin
        i_c_rsp_valid = (k == v.d2);
        i_c_rdata     = (k == v.d2) ? v.sdata : ~v.sdata;
        @(negedge i_clk);
        check_output("c_valid_drop", o_c_valid, 0);
        @(posedge i_clk);
        #1;
      end
      i_c_rsp_valid = 1'b0;
    end else begin
      for (int k = 0; k <= v.d1; k++) begin
        i_wb_ack      = (k == v.d1) && !v.serr;
        i_wb_err      = (k == v.d1) && v.serr;
        i_wb_data     = (k == v.d1) ? v.sdata : ~v.sdata;
        i_c_rsp_valid = 1'b1;
        @(negedge i_clk);
        check_output("wb_hold", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel},
                     {2'b11, v.we, v.addr, v.wdata, v.sel});
        @(posedge i_clk);
        #1;
      end
      i_wb_ack      = 1'b0;
      i_wb_err      = 1'b0;
      i_c_rsp_valid = 1'b0;
      @(negedge i_clk);
      check_output("wb_cyc_drop", {o_wb_cyc, o_wb_stb}, 2'b00);
    end
    wait_idle("back_to_idle");
    check_output("rsp_count", rsp_seen - rsp_before, 1);
    if (v.cach) check_output("no_wb_on_cache", wb_seen, 0);
    else check_output("no_cache_on_wb", cache_seen, 0);
    if (v.lat != 0) check_output("latency", (t_rsp - t_acc) / 10, v.lat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int cnt;
    int rsp_before;
    exp_t e;
    //          cach  we    addr          wdata         sel   d1 d2 sdata         serr  exp_rdata     err  lat
    vecs[0] = '{1'b1, 1'b0, 32'h10000040, 32'h0,        4'hF, 0, 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h30000000, 32'h41,       4'h1, 3, 0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 32'h30000010, 32'h0,        4'hF, 1, 0, 32'h0,        1'b1, 32'h0,        1'b1, 0};
    vecs[3] = '{1'b0, 1'b0, 32'h20000004, 32'h0,        4'hF, 0, 0, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b1, 32'h10000080, 32'h0000A5A5, 4'hF, 2, 0, 32'h00000055, 1'b0, 32'h0,        1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 32'h100000FC, 32'h0,        4'hF, 1, 3, 32'h0BADBEEF, 1'b0, 32'h0BADBEEF, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b0, 32'h20000100, 32'h0,        4'h3, 2, 0, 32'h00C0FFEE, 1'b0, 32'h00C0FFEE, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b0, 32'h10000200, 32'h0,        4'hF, 0, 0, 32'h76543210, 1'b0, 32'h76543210, 1'b0, 3};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_output("rst_ctrl", {o_req_ready, o_rsp_valid, o_rsp_err, o_c_valid, o_wb_cyc, o_wb_stb},
                 6'b100000);
    check_output("rst_data", {o_rsp_rdata, o_c_addr, o_wb_addr, o_wb_data}, 128'h0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    // Spurious cache response and Wishbone ack/err while idle.
    rsp_before = rsp_seen;
    i_c_rsp_valid = 1'b1;
    i_wb_ack = 1'b1;
    i_wb_err = 1'b1;
    @(negedge i_clk);
    check_output("spur_idle_ready", o_req_ready, 1);
    @(posedge i_clk);
    #1;
    i_c_rsp_valid = 1'b0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    @(negedge i_clk);
    check_output("spur_idle_state", {o_req_ready, o_c_valid, o_wb_cyc}, 3'b100);
    check_output("spur_idle_no_rsp", rsp_seen - rsp_before, 0);
    @(posedge i_clk);
    #1;

    // Reset in the middle of an uncached access abandons it.
    rsp_before = rsp_seen;
    i_req_valid = 1'b1;
    i_req_addr = 32'h30000020;
    i_req_we = 1'b0;
    i_cachable = 1'b0;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check_output("rst_mid_cyc_before", o_wb_cyc, 1);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    check_output("rst_mid_cyc_after", {o_wb_cyc, o_wb_stb, o_rsp_valid}, 3'b000);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    i_wb_ack = 1'b1;
    @(negedge i_clk);
    check_output("rst_mid_ready", o_req_ready, 1);
    @(posedge i_clk);
    #1;
    i_wb_ack = 1'b0;
    repeat (3) @(negedge i_clk);
    check_output("rst_mid_no_rsp", rsp_seen - rsp_before, 0);
    @(posedge i_clk);
    #1;

    // Uncached read with a silent slave: watchdog build times out, default build keeps waiting.
    rsp_before = rsp_seen;
    i_req_valid = 1'b1;
    i_req_addr = 32'h30000040;
    i_req_we = 1'b0;
    i_cachable = 1'b0;
    i_wb_data = 32'hFFFFFFFF;
`ifdef MEM_REQ_ROUTER_TIMEOUT_EN
    e.rdata = '0;
    e.err = 1'b1;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_wb_cyc !== 1'b1) break;
      cnt++;
    end
    check_output("timeout_cyc_cycles", cnt, TO);
`else
    e.rdata = 32'h0000BEEF;
    e.err = 1'b0;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_clk);
      if (o_wb_cyc === 1'b1) cnt++;
      @(posedge i_clk);
      #1;
    end
    check_output("no_timeout_wait", cnt, 12);
    i_wb_ack = 1'b1;
    i_wb_data = 32'h0000BEEF;
    @(posedge i_clk);
    #1;
    i_wb_ack = 1'b0;
    @(negedge i_clk);
    check_output("late_ack_cyc_drop", o_wb_cyc, 0);
`endif
    wait_idle("watchdog_idle");
    check_output("watchdog_rsp_count", rsp_seen - rsp_before, 1);
    i_wb_data = '0;

    check_output("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
